// File: rtl/drive_pkg.sv
// Shared encodings for the drive command scheduler: motor directions,
// PS/2 key indices ({extend, scancode}) and ramp FSM states.
package drive_pkg;

    typedef enum logic [2:0] {
        DIR_STOP  = 3'd0,
        DIR_FWD   = 3'd1,
        DIR_REV   = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4,
        DIR_BRAKE = 3'd5
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEL,
        ST_CRUISE,
        ST_DECEL,
        ST_BRAKE
    } state_t;

    localparam logic [8:0] SC_W     = 9'h01D;
    localparam logic [8:0] SC_UP    = 9'h175;
    localparam logic [8:0] SC_S     = 9'h01B;
    localparam logic [8:0] SC_DOWN  = 9'h172;
    localparam logic [8:0] SC_A     = 9'h01C;
    localparam logic [8:0] SC_LEFT  = 9'h16B;
    localparam logic [8:0] SC_D     = 9'h023;
    localparam logic [8:0] SC_RIGHT = 9'h174;
    localparam logic [8:0] SC_SPACE = 9'h029;

    // Direction bound to a key, DIR_STOP for anything that is not a direction key.
    function automatic dir_t key_to_dir(input logic [8:0] code);
        case (code)
            SC_W, SC_UP:     return DIR_FWD;
            SC_S, SC_DOWN:   return DIR_REV;
            SC_A, SC_LEFT:   return DIR_LEFT;
            SC_D, SC_RIGHT:  return DIR_RIGHT;
            default:         return DIR_STOP;
        endcase
    endfunction

endpackage

// File: rtl/drive_key_arbiter.sv
// Resolves the held direction keys into one requested direction.
// The most recently pressed direction wins while it is held; otherwise a
// fixed priority FWD > REV > LEFT > RIGHT picks among the keys still down.
module drive_key_arbiter
    import drive_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] key_down,
    input  logic [8:0]   last_change,
    input  logic         key_valid,
    output logic [3:0]   held,
    output dir_t         req_dir
);

    dir_t last_dir;
    dir_t pressed_dir;
    logic last_held;

    assign pressed_dir = key_to_dir(last_change);

    // Per-direction held flags: either of the two bound keys counts.
    always_comb begin
        held[0] = key_down[SC_W] | key_down[SC_UP];
        held[1] = key_down[SC_S] | key_down[SC_DOWN];
        held[2] = key_down[SC_A] | key_down[SC_LEFT];
        held[3] = key_down[SC_D] | key_down[SC_RIGHT];
    end

    // Remember the latest direction press; releases never touch it.
    // NOTE: sequential state is written with non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_dir <= DIR_STOP;
        end else if (key_valid && key_down[last_change] && pressed_dir != DIR_STOP) begin
            last_dir <= pressed_dir;
        end
    end

    // Last press if still held, else fixed-priority fallback, else STOP.
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        last_held = 1'b0;
        req_dir   = DIR_STOP;
        case (last_dir)
            DIR_FWD:   last_held = held[0];
            DIR_REV:   last_held = held[1];
            DIR_LEFT:  last_held = held[2];
            DIR_RIGHT: last_held = held[3];
            default:   last_held = 1'b0;
        endcase
        if (last_held)    req_dir = last_dir;
        else if (held[0]) req_dir = DIR_FWD;
        else if (held[1]) req_dir = DIR_REV;
        else if (held[2]) req_dir = DIR_LEFT;
        else if (held[3]) req_dir = DIR_RIGHT;
    end

endmodule

// File: rtl/drive_cmd_scheduler.sv
// Turns keyboard state into one arbitrated {dir, speed} motor command:
// speed ramp with forced pass through zero on direction change, brake
// override (space or watchdog), and a coalescing valid/ready output stage.
module drive_cmd_scheduler
    import drive_pkg::*;
#(
    parameter int RAMP_DIV   = 100000,
    parameter int SPEED_STEP = 8,
    parameter int MAX_SPEED  = 255,
    parameter int TURN_SPEED = 160,
    parameter int WDT_CYCLES = 50000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] key_down,
    input  logic [8:0]   last_change,
    input  logic         key_valid,
    output logic [2:0]   cmd_dir,
    output logic [7:0]   cmd_speed,
    output logic         cmd_valid,
    input  logic         cmd_ready,
    output logic         wdt_fault
);

    localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RAMP_DIV - 1);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);
    localparam logic [7:0] STEP     = 8'(SPEED_STEP);
    localparam logic [7:0] MAX_SPD  = 8'(MAX_SPEED);
    localparam logic [7:0] TURN_SPD = 8'(TURN_SPEED);

    logic [3:0]       held;
    dir_t             req_dir;
    logic [PRE_W-1:0] pre_cnt;
    logic             tick;
    logic [WDT_W-1:0] wdt_cnt;
    logic             brake_req;
    state_t           state, state_n;
    dir_t             cur_dir, cur_dir_n;
    logic [7:0]       speed, speed_n;
    logic [7:0]       target;
    logic [8:0]       accel_sum;
    logic [7:0]       accel_speed;
    logic [7:0]       decel_speed;
    logic [2:0]       last_acc_dir;
    logic [7:0]       last_acc_speed;

    drive_key_arbiter u_arbiter (
        .clk         (clk),
        .rst         (rst),
        .key_down    (key_down),
        .last_change (last_change),
        .key_valid   (key_valid),
        .held        (held),
        .req_dir     (req_dir)
    );

    assign tick        = (pre_cnt == PRE_LAST);
    assign brake_req   = key_down[SC_SPACE] | wdt_fault;
    assign target      = (cur_dir == DIR_FWD || cur_dir == DIR_REV) ? MAX_SPD : TURN_SPD;
    assign accel_sum   = {1'b0, speed} + {1'b0, STEP};
    assign accel_speed = (accel_sum >= {1'b0, target}) ? target : accel_sum[7:0];
    assign decel_speed = (speed > STEP) ? speed - STEP : 8'd0;

    // Free-running ramp prescaler; tick marks the wrap cycle.
    always_ff @(posedge clk) begin
        if (rst || tick) pre_cnt <= '0;
        else             pre_cnt <= pre_cnt + 1'b1;
    end

    // Watchdog: saturating idle counter, sticky fault cleared once all direction keys are up.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_cnt   <= '0;
            wdt_fault <= 1'b0;
        end else begin
            if (key_valid || req_dir == DIR_STOP) wdt_cnt <= '0;
            else if (wdt_cnt != WDT_LAST)         wdt_cnt <= wdt_cnt + 1'b1;
            if (held == 4'b0000)                  wdt_fault <= 1'b0;
            else if (wdt_cnt == WDT_LAST)         wdt_fault <= 1'b1;
        end
    end

    // Ramp FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cur_dir <= DIR_STOP;
            speed   <= 8'd0;
        end else begin
            state   <= state_n;
            cur_dir <= cur_dir_n;
            speed   <= speed_n;
        end
    end

    // Ramp FSM next state: brake first, then ramp toward the requested direction.
    always_comb begin
        state_n   = state;
        cur_dir_n = cur_dir;
        speed_n   = speed;
        if (brake_req) begin
            state_n   = ST_BRAKE;
            cur_dir_n = DIR_BRAKE;
            speed_n   = 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    speed_n = 8'd0;
                    if (req_dir != DIR_STOP) begin
                        cur_dir_n = req_dir;
                        state_n   = ST_ACCEL;
                    end
                end
                ST_ACCEL: begin
                    if (req_dir != cur_dir) begin
                        state_n = ST_DECEL;
                    end else if (tick) begin
                        speed_n = accel_speed;
                        if (accel_speed == target) state_n = ST_CRUISE;
                    end
                end
                ST_CRUISE: begin
                    if (req_dir != cur_dir) state_n = ST_DECEL;
                end
                ST_DECEL: begin
                    if (req_dir == cur_dir) begin
                        state_n = ST_ACCEL;
                    end else if (tick) begin
                        speed_n = decel_speed;
                        if (decel_speed == 8'd0) begin
                            state_n   = ST_IDLE;
                            cur_dir_n = DIR_STOP;
                        end
                    end
                end
                ST_BRAKE: begin
                    state_n   = ST_IDLE;
                    cur_dir_n = DIR_STOP;
                    speed_n   = 8'd0;
                end
                default: begin
                    state_n   = ST_IDLE;
                    cur_dir_n = DIR_STOP;
                    speed_n   = 8'd0;
                end
            endcase
        end
    end

    // Output stage: offer the newest internal command, hold it until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_dir        <= DIR_STOP;
            cmd_speed      <= 8'd0;
            cmd_valid      <= 1'b0;
            last_acc_dir   <= DIR_STOP;
            last_acc_speed <= 8'd0;
        end else if (cmd_valid && cmd_ready) begin
            last_acc_dir   <= cmd_dir;
            last_acc_speed <= cmd_speed;
            cmd_valid      <= 1'b0;
        end else if (!cmd_valid && {cur_dir, speed} != {last_acc_dir, last_acc_speed}) begin
            cmd_dir   <= cur_dir;
            cmd_speed <= speed;
            cmd_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_drive_cmd_scheduler.sv
// Self-checking bench for drive_cmd_scheduler: directed scenarios followed by
// randomized key/ready traffic, all compared cycle by cycle to a behavioural model.
module tb_drive_cmd_scheduler;

    localparam int RAMP_DIV = 4;
    localparam int STEP     = 64;
    localparam int MAXS     = 255;
    localparam int TURNS    = 128;
    localparam int WDT      = 64;

    localparam int K_W = 'h01D, K_S = 'h01B, K_A = 'h01C, K_SPACE = 'h029;
    localparam int D_STOP = 0, D_FWD = 1, D_REV = 2, D_LEFT = 3, D_BRAKE = 5;

    int key_a [5] = '{0, 'h01D, 'h01B, 'h01C, 'h023};
    int key_b [5] = '{0, 'h175, 'h172, 'h16B, 'h174};
    int pool [10] = '{'h01D, 'h175, 'h01B, 'h172, 'h01C, 'h16B, 'h023, 'h174, 'h029, 'h015};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [511:0] key_down = '0;
    logic [8:0]   last_change = '0;
    logic         key_valid = 1'b0;
    logic         cmd_ready = 1'b1;
    logic [2:0]   cmd_dir;
    logic [7:0]   cmd_speed;
    logic         cmd_valid;
    logic         wdt_fault;

    always #5 clk = ~clk;

    drive_cmd_scheduler #(
        .RAMP_DIV   (RAMP_DIV),
        .SPEED_STEP (STEP),
        .MAX_SPEED  (MAXS),
        .TURN_SPEED (TURNS),
        .WDT_CYCLES (WDT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_down    (key_down),
        .last_change (last_change),
        .key_valid   (key_valid),
        .cmd_dir     (cmd_dir),
        .cmd_speed   (cmd_speed),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .wdt_fault   (wdt_fault)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_UP, M_HOLD, M_DOWN, M_BRAKE} mode_t;

    mode_t m_mode;
    int    m_last, m_cur, m_spd, m_pre, m_wcnt;
    bit    m_fault, m_oval;
    int    m_odir, m_ospd, m_adir, m_aspd;

    function automatic int dir_of(input int code);
        for (int d = 1; d <= 4; d++)
            if (code == key_a[d] || code == key_b[d]) return d;
        return 0;
    endfunction

    function automatic int target_of(input int d);
        return (d == D_FWD || d == D_REV) ? MAXS : TURNS;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_last = 0; m_cur = 0; m_spd = 0; m_pre = 0; m_wcnt = 0;
        m_fault = 0; m_oval = 0; m_odir = 0; m_ospd = 0; m_adir = 0; m_aspd = 0;
    endtask

    // One clock edge of the specified behaviour, from pre-edge inputs and state.
    task automatic model_step();
        bit    held [5];
        bit    any_held, tick, brk;
        int    req, pd;
        mode_t n_mode;
        int    n_last, n_cur, n_spd, n_wcnt, n_odir, n_ospd, n_adir, n_aspd;
        bit    n_fault, n_oval;
        if (rst) begin
            model_reset();
            return;
        end
        any_held = 0;
        held[0]  = 0;
        for (int d = 1; d <= 4; d++) begin
            held[d]  = key_down[key_a[d]] || key_down[key_b[d]];
            any_held = any_held || held[d];
        end
        req = 0;
        if (m_last != 0 && held[m_last]) req = m_last;
        else for (int d = 4; d >= 1; d--) if (held[d]) req = d;
        tick = (m_pre == RAMP_DIV - 1);
        brk  = key_down[K_SPACE] || m_fault;

        n_mode = m_mode; n_cur = m_cur; n_spd = m_spd;
        if (brk) begin
            n_mode = M_BRAKE; n_cur = D_BRAKE; n_spd = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    n_spd = 0;
                    if (req != 0) begin n_cur = req; n_mode = M_UP; end
                end
                M_UP: begin
                    if (req != m_cur) n_mode = M_DOWN;
                    else if (tick) begin
                        n_spd = m_spd + STEP;
                        if (n_spd >= target_of(m_cur)) begin n_spd = target_of(m_cur); n_mode = M_HOLD; end
                    end
                end
                M_HOLD: if (req != m_cur) n_mode = M_DOWN;
                M_DOWN: begin
                    if (req == m_cur) n_mode = M_UP;
                    else if (tick) begin
                        n_spd = m_spd - STEP;
                        if (n_spd <= 0) begin n_spd = 0; n_mode = M_IDLE; n_cur = D_STOP; end
                    end
                end
                default: begin n_mode = M_IDLE; n_cur = D_STOP; n_spd = 0; end
            endcase
        end

        n_wcnt = (key_valid || req == 0) ? 0 : ((m_wcnt < WDT - 1) ? m_wcnt + 1 : m_wcnt);
        n_fault = m_fault;
        if (!any_held) n_fault = 0;
        else if (m_wcnt == WDT - 1) n_fault = 1;

        n_oval = m_oval; n_odir = m_odir; n_ospd = m_ospd; n_adir = m_adir; n_aspd = m_aspd;
        if (m_oval && cmd_ready) begin
            n_adir = m_odir; n_aspd = m_ospd; n_oval = 0;
        end else if (!m_oval && (m_cur != m_adir || m_spd != m_aspd)) begin
            n_odir = m_cur; n_ospd = m_spd; n_oval = 1;
        end

        n_last = m_last;
        pd = dir_of(int'(last_change));
        if (key_valid && key_down[last_change] && pd != 0) n_last = pd;

        m_mode = n_mode; m_cur = n_cur; m_spd = n_spd; m_wcnt = n_wcnt; m_fault = n_fault;
        m_oval = n_oval; m_odir = n_odir; m_ospd = n_ospd; m_adir = n_adir; m_aspd = n_aspd;
        m_last = n_last;
        m_pre  = tick ? 0 : m_pre + 1;
    endtask

    // ---------------- stimulus helpers ----------------
    logic [10:0] acc_q [$];

    function automatic logic [10:0] cmd(input int d, input int s);
        return {3'(d), 8'(s)};
    endfunction

    task automatic cycle();
        if (cmd_valid === 1'b1 && cmd_ready) acc_q.push_back({cmd_dir, cmd_speed});
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("cmd_valid", 32'(cmd_valid), 32'(m_oval));
        check("cmd_dir",   32'(cmd_dir),   32'(m_odir));
        check("cmd_speed", 32'(cmd_speed), 32'(m_ospd));
        check("wdt_fault", 32'(wdt_fault), 32'(m_fault));
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic key(input int k, input bit v);
        key_down[k] = v;
        last_change = 9'(k);
        key_valid   = 1'b1;
        cycle();
        key_valid   = 1'b0;
    endtask

    function automatic logic [10:0] acc_at(input int i);
        return (i < acc_q.size()) ? acc_q[i] : 11'h7FF;
    endfunction

    function automatic logic [10:0] acc_last();
        return (acc_q.size() > 0) ? acc_q[acc_q.size() - 1] : 11'h7FF;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [10:0] exp1 [5];
        bit          seen_rev, order_ok;
        int          rate, rpct, len, k;

        model_reset();
        rst = 1'b1;
        cmd_ready = 1'b1;
        run(3);
        rst = 1'b0;
        run(2);

        // Press W: entering ACCEL publishes FWD/0, then one command per tick up to 255.
        acc_q.delete();
        key(K_W, 1);
        run(30);
        exp1 = '{cmd(D_FWD, 0), cmd(D_FWD, 64), cmd(D_FWD, 128), cmd(D_FWD, 192), cmd(D_FWD, 255)};
        check("s1_count", 32'(acc_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) check("s1_cmd", 32'(acc_at(i)), 32'(exp1[i]));

        // Press S with W held: FWD must fully decelerate before any REV command.
        acc_q.delete();
        key(K_S, 1);
        run(60);
        seen_rev = 0;
        order_ok = 1;
        foreach (acc_q[i]) begin
            if (acc_q[i][10:8] == 3'(D_REV)) seen_rev = 1;
            if (acc_q[i][10:8] == 3'(D_FWD) && seen_rev) order_ok = 0;
        end
        check("s2_order", 32'(order_ok), 32'd1);
        check("s2_final", 32'(acc_last()), 32'(cmd(D_REV, 255)));

        // Release S (falls back to held W), then press and release A.
        key(K_S, 0);
        run(60);
        check("s3_fwd", 32'(acc_last()), 32'(cmd(D_FWD, 255)));
        key(K_A, 1);
        run(50);
        check("s3_left", 32'(acc_last()), 32'(cmd(D_LEFT, 128)));
        key(K_A, 0);
        run(50);
        check("s3_back", 32'(acc_last()), 32'(cmd(D_FWD, 255)));

        // Space while cruising: BRAKE/0, release gives STOP/0 then re-ramp on held W.
        acc_q.delete();
        key(K_SPACE, 1);
        run(5);
        check("s4_brake", 32'(acc_at(0)), 32'(cmd(D_BRAKE, 0)));
        acc_q.delete();
        key(K_SPACE, 0);
        run(3);
        check("s4_stop", 32'(acc_at(0)), 32'(cmd(D_STOP, 0)));
        run(40);
        check("s4_reramp", 32'(acc_last()), 32'(cmd(D_FWD, 255)));

        // No key events while W held: watchdog fault and brake; release W clears it.
        run(80);
        check("s5_fault", 32'(wdt_fault), 32'd1);
        check("s5_brake", 32'(acc_last()), 32'(cmd(D_BRAKE, 0)));
        acc_q.delete();
        key(K_W, 0);
        run(5);
        check("s5_clear", 32'(wdt_fault), 32'd0);
        check("s5_stop", 32'(acc_last()), 32'(cmd(D_STOP, 0)));

        // Ready low during a ramp: first command held, next one coalesced to current speed.
        acc_q.delete();
        cmd_ready = 1'b0;
        key(K_W, 1);
        run(20);
        cmd_ready = 1'b1;
        run(20);
        check("s6_count", 32'(acc_q.size()), 32'd2);
        check("s6_first", 32'(acc_at(0)), 32'(cmd(D_FWD, 0)));
        check("s6_coalesced", 32'(acc_at(1)), 32'(cmd(D_FWD, 255)));

        // Randomized traffic with occasional mid-run resets.
        for (int ph = 0; ph < 30; ph++) begin
            rate = $urandom_range(0, 15);
            rpct = $urandom_range(20, 100);
            len  = $urandom_range(40, 150);
            for (int c = 0; c < len; c++) begin
                cmd_ready = ($urandom_range(1, 100) <= rpct);
                rst = ($urandom_range(0, 999) == 0);
                if (rate != 0 && $urandom_range(0, rate - 1) == 0) begin
                    k = pool[$urandom_range(0, 9)];
                    if (k == K_SPACE && !key_down[k] && $urandom_range(0, 2) != 0) k = K_W;
                    key_down[k] = ~key_down[k];
                    last_change = 9'(k);
                    key_valid   = 1'b1;
                end
                cycle();
                key_valid = 1'b0;
                rst = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) begin
                key_down    = '0;
                last_change = 9'(K_W);
                key_valid   = 1'b1;
                cycle();
                key_valid   = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
